// File: rtl/rs_scheduler_pkg.sv
// Shared types for the reservation-station scheduler.
//   OP_W / TAG_W / VAL_W : operation-code, tag and operand widths
//   TAG_NONE             : tag value meaning "operand value present"
//   rs_entry_t           : one reservation-station slot
//   rs_wake()            : applies a CDB broadcast to one entry
package rs_scheduler_pkg;

  localparam int OP_W  = 10;
  localparam int TAG_W = 5;
  localparam int VAL_W = 32;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [VAL_W-1:0] vj;
    logic [VAL_W-1:0] vk;
    logic [TAG_W-1:0] dest;
  } rs_entry_t;

  // Operands j and k are matched independently, so one broadcast can
  // satisfy both when an instruction uses the same producer twice.
  function automatic rs_entry_t rs_wake(input rs_entry_t        e,
                                        input logic             cdb_valid,
                                        input logic [TAG_W-1:0] cdb_tag,
                                        input logic [VAL_W-1:0] cdb_value);
    rs_entry_t r;
    r = e;
    if (cdb_valid && e.valid && (e.qj == cdb_tag)) begin
      r.vj = cdb_value;
      r.qj = TAG_NONE;
    end
    if (cdb_valid && e.valid && (e.qk == cdb_tag)) begin
      r.vk = cdb_value;
      r.qk = TAG_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_scheduler_select.sv
// Lowest-index priority picker for the scheduler.
//   i_ready : one bit per entry, set when the entry can issue
//   o_grant : one-hot grant of the lowest set bit (zero if none)
//   o_idx   : binary index of the granted entry (zero if none)
//   o_any   : at least one bit of i_ready is set
module rs_select #(
  parameter int DEPTH = 4,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_ready,
  output logic [DEPTH-1:0] o_grant,
  output logic [IDXW-1:0]  o_idx,
  output logic             o_any
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_ready[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = IDXW'(i);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_scheduler.sv
// Reservation-station scheduler for one functional unit.
// Collapsing age-ordered queue: slot 0 is always the oldest entry.
//   clk, reset (async, active-low), flush (sync clear)
//   disp_*  : dispatch handshake and decoded instruction from decode
//   cdb_*   : common data bus broadcast used to wake waiting operands
//   issue_* : oldest fully-ready entry offered to the functional unit
//   count   : number of occupied entries
// TAGW must equal the package TAG_W (entries are stored as rs_entry_t).
module rs_scheduler
  import rs_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = TAG_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [TAGW-1:0]            disp_qj,
  input  logic [TAGW-1:0]            disp_qk,
  input  logic [VAL_W-1:0]           disp_vj,
  input  logic [VAL_W-1:0]           disp_vk,
  input  logic [TAGW-1:0]            disp_dest,
  input  logic                       cdb_valid,
  input  logic [TAGW-1:0]            cdb_tag,
  input  logic [VAL_W-1:0]           cdb_value,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [OP_W-1:0]            issue_op,
  output logic [VAL_W-1:0]           issue_vj,
  output logic [VAL_W-1:0]           issue_vk,
  output logic [TAGW-1:0]            issue_dest,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  rs_entry_t        r_ent [DEPTH];
  logic [CNTW-1:0]  r_count;

  rs_entry_t        w_pad [DEPTH+1];
  rs_entry_t        w_nxt [DEPTH];
  rs_entry_t        w_new;
  rs_entry_t        w_sel;
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_grant;
  logic [DEPTH-1:0] w_shift;
  logic [IDXW-1:0]  w_idx;
  logic             w_any;
  logic             w_issue;
  logic             w_disp;
  logic [CNTW-1:0]  w_wr_idx;
  logic [CNTW-1:0]  w_count_nxt;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_rdy[i] = r_ent[i].valid && (r_ent[i].qj == TAG_NONE) && (r_ent[i].qk == TAG_NONE);
    end
  end

  rs_select #(.DEPTH(DEPTH), .IDXW(IDXW)) u_select (
    .i_ready (w_rdy),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // disp_ready depends on occupancy only, so a slot freed by an issue is
  // offered to decode one cycle later and issue_ready never reaches it.
  assign disp_ready  = (r_count < CNTW'(DEPTH));
  assign w_disp      = disp_valid && disp_ready;
  assign w_issue     = w_any && issue_ready;
  assign w_wr_idx    = w_issue ? (r_count - 1'b1) : r_count;
  assign w_count_nxt = r_count + CNTW'(w_disp) - CNTW'(w_issue);

  assign w_sel       = r_ent[w_idx];
  assign issue_valid = w_any;
  assign issue_op    = w_any ? w_sel.op   : '0;
  assign issue_vj    = w_any ? w_sel.vj   : '0;
  assign issue_vk    = w_any ? w_sel.vk   : '0;
  assign issue_dest  = w_any ? w_sel.dest : '0;
  assign count       = r_count;

  // Slots at and above the granted one take their upper neighbour when an
  // issue fires; the extra empty pad slot feeds the topmost entry.
  always_comb begin
    w_shift[0] = w_grant[0];
    for (int i = 1; i < DEPTH; i++) begin
      w_shift[i] = w_shift[i-1] | w_grant[i];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_pad[i] = r_ent[i];
    end
    w_pad[DEPTH] = '0;
  end

  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.op    = disp_op;
    w_new.qj    = disp_qj;
    w_new.qk    = disp_qk;
    w_new.vj    = disp_vj;
    w_new.vk    = disp_vk;
    w_new.dest  = disp_dest;
    // Same-cycle bypass: a dispatching operand can catch the broadcast.
    w_new       = rs_wake(w_new, cdb_valid, cdb_tag, cdb_value);
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = (w_issue && w_shift[i]) ? w_pad[i+1] : w_pad[i];
      w_nxt[i] = rs_wake(w_nxt[i], cdb_valid, cdb_tag, cdb_value);
      if (w_disp && (w_wr_idx == CNTW'(i))) begin
        w_nxt[i] = w_new;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
      r_count <= '0;
    end else if (flush) begin
      // Flush wins over any same-cycle dispatch or issue.
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i].valid <= 1'b0;
      end
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= w_nxt[i];
      end
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_rs_scheduler.sv
// Self-checking bench for rs_scheduler: directed scenarios followed by
// randomized traffic, all compared each cycle against a queue-based model.
module tb_rs_scheduler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [9:0]  disp_op = '0;
  logic [4:0]  disp_qj = '0, disp_qk = '0, disp_dest = '0;
  logic [31:0] disp_vj = '0, disp_vk = '0;
  logic        cdb_valid = 1'b0;
  logic [4:0]  cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [9:0]  issue_op;
  logic [31:0] issue_vj, issue_vk;
  logic [4:0]  issue_dest;
  logic [2:0]  count;

  rs_scheduler #(.DEPTH(DEPTH), .TAGW(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_dest(disp_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_dest(issue_dest),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  op;
    logic [4:0]  qj, qk, dest;
    logic [31:0] vj, vk;
  } m_t;

  m_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_ready();
    int sel;
    sel = -1;
    foreach (q[i]) if (sel < 0 && q[i].qj == 0 && q[i].qk == 0) sel = i;
    return sel;
  endfunction

  task automatic compare_outputs();
    int sel;
    sel = first_ready();
    check("disp_ready", 64'(disp_ready), 64'(q.size() < DEPTH));
    check("count", 64'(count), 64'(q.size()));
    check("issue_valid", 64'(issue_valid), 64'(sel >= 0));
    if (sel >= 0) begin
      check("issue_op", 64'(issue_op), 64'(q[sel].op));
      check("issue_vj", 64'(issue_vj), 64'(q[sel].vj));
      check("issue_vk", 64'(issue_vk), 64'(q[sel].vk));
      check("issue_dest", 64'(issue_dest), 64'(q[sel].dest));
    end else begin
      check("idle_outs", {22'd0, issue_op, issue_vj[15:0], issue_vk[10:0], issue_dest}, 64'd0);
    end
  endtask

  // One clock: check the state at the falling edge, drive inputs, advance the model.
  task automatic cyc(input bit dv, input logic [9:0] op, input logic [4:0] qj, input logic [31:0] vj,
                     input logic [4:0] qk, input logic [31:0] vk, input logic [4:0] dst,
                     input bit cv, input logic [4:0] ct, input logic [31:0] cval,
                     input bit ir, input bit fl);
    int sel;
    bit iss, dsp;
    m_t e;
    @(negedge clk);
    compare_outputs();
    disp_valid = dv; disp_op = op; disp_qj = qj; disp_vj = vj;
    disp_qk = qk; disp_vk = vk; disp_dest = dst;
    cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
    issue_ready = ir; flush = fl;
    sel = first_ready();
    iss = (sel >= 0) && ir;
    dsp = dv && (q.size() < DEPTH);
    if (fl) begin
      q.delete();
    end else begin
      if (iss) q.delete(sel);
      foreach (q[i]) begin
        if (cv && q[i].qj == ct) begin q[i].vj = cval; q[i].qj = 0; end
        if (cv && q[i].qk == ct) begin q[i].vk = cval; q[i].qk = 0; end
      end
      if (dsp) begin
        e.op = op; e.qj = qj; e.qk = qk; e.vj = vj; e.vk = vk; e.dest = dst;
        if (cv && e.qj == ct) begin e.vj = cval; e.qj = 0; end
        if (cv && e.qk == ct) begin e.vk = cval; e.qk = 0; end
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input bit ir);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir, 0);
  endtask

  initial begin
    // Reset held: outputs must already be at their reset values.
    #2;
    check("rst_disp_ready", 64'(disp_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_outs", {22'd0, issue_op, issue_vj[15:0], issue_vk[10:0], issue_dest}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    idle(0);
    // Single ready instruction issues the next cycle.
    cyc(1, 10'h033, 0, 5, 0, 7, 3, 0, 0, 0, 1, 0);
    idle(1); idle(1);
    // Older A waits on tag 4; younger B overtakes it, then A wakes.
    cyc(1, 10'h0A1, 4, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    cyc(1, 10'h0B2, 0, 2, 0, 3, 2, 0, 0, 0, 1, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'hDEAD, 1, 0);
    idle(1); idle(1);
    // Dispatch bypass on operand k.
    cyc(1, 10'h0C3, 0, 9, 6, 0, 7, 1, 6, 32'h11, 1, 0);
    idle(1); idle(1);
    // Fill all slots waiting on tag 9, then wake them together.
    for (int i = 0; i < DEPTH; i++) cyc(1, 10'(i + 1), 9, 0, 0, 32'(i), 5'(i + 10), 0, 0, 0, 0, 0);
    cyc(1, 10'h3FF, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 10'(i + 32), 0, 32'(i), 0, 32'(i), 5'(i + 1), 0, 0, 0, 1, 0);
    idle(1); idle(1); idle(1);
    // Flush with a same-cycle dispatch and issue.
    for (int i = 0; i < 3; i++) cyc(1, 10'(i + 64), 0, 32'(i), 0, 32'(i), 5'(i + 2), 0, 0, 0, 0, 0);
    cyc(1, 10'h155, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1);
    idle(1); idle(1);

    // Randomized traffic with small tag space so wakeups are frequent.
    for (int n = 0; n < 2000; n++) begin
      automatic bit          dv   = ($urandom_range(0, 9) < 6);
      automatic logic [4:0]  qj   = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 9));
      automatic logic [4:0]  qk   = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 9));
      automatic bit          cv   = ($urandom_range(0, 9) < 4);
      automatic logic [4:0]  ct   = 5'($urandom_range(1, 9));
      automatic bit          ir   = ($urandom_range(0, 3) != 0);
      automatic bit          fl   = ($urandom_range(0, 63) == 0);
      cyc(dv, 10'($urandom), qj, $urandom, qk, $urandom, 5'($urandom), cv, ct, $urandom, ir, fl);
    end

    // Asynchronous reset in mid-cycle with entries present.
    for (int i = 0; i < 3; i++) cyc(1, 10'(i + 100), 5'(i), 32'(i), 0, 32'(i), 5'(i), 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    disp_valid = 1'b0; cdb_valid = 1'b0; issue_ready = 1'b0; flush = 1'b0;
    reset = 1'b0;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_issue_valid", 64'(issue_valid), 64'd0);
    check("async_rst_disp_ready", 64'(disp_ready), 64'd1);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    idle(0); idle(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
